// File: rtl/periph_pkg.sv
// Shared constants and types for the memory-mapped peripheral's input conditioning.
// Latency: n/a. This package holds only constants and types.
// Backpressure: n/a.
package periph_pkg;

    // Number of board DIP switch lines.
    localparam int SW_WIDTH              = 8;

    // 10 ms of contact settling at 50 MHz.
    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;

    // Counter width that holds DEBOUNCE_CYCLES_50MHZ-1.
    localparam int DEBOUNCE_CNT_W        = 19;

    // Short settling window so simulations finish quickly.
    localparam int DEBOUNCE_CYCLES_SIM   = 4;

    // Per-bit edge event produced when a debounced level is accepted.
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_RISE = 2'd1,
        EV_FALL = 2'd2
    } sw_event_e;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw pins in, debounced level and edge pulses out.
// Latency: n/a. The interface contains wiring only.
// Backpressure: none. All signals are level or single-cycle pulse; there is no handshake.
//
// Signals:
//   sw_raw  : raw asynchronous switch pins (driven by the board / master side)
//   sw_db   : debounced level
//   rise    : one-cycle pulse per bit on a 0->1 debounced transition
//   fall    : one-cycle pulse per bit on a 1->0 debounced transition
//   changed : high in the same cycle as any rise/fall bit
interface switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    // Board and consumer side: drives the pins and observes the conditioned result.
    modport master (
        output sw_raw,
        input  sw_db,
        input  rise,
        input  fall,
        input  changed
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw_db,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/switch_debouncer_bit.sv
// One switch line: 2-flop synchronizer, stability counter, debounced level and edge pulses.
// Latency: STABLE_CYCLES+2 clk edges from the first sampling edge to the db/rise/fall update.
// Backpressure: none. A new level is accepted only after STABLE_CYCLES consecutive mismatching cycles.
//
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   sw_raw     : raw asynchronous pin
//   db         : registered debounced level
//   rise/fall  : registered one-cycle pulses, aligned with the db update
//   pulse_nxt  : next-state pulse term (rise|fall), used to register a combined flag alongside
module debounce_bit
    import periph_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W         = DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic pulse_nxt
);

    // The count value at which the new level is accepted.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_q;
    logic             fall_q;

    logic             db_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    sw_event_e        ev_nxt;

    // State register. s1 feeds s2 directly so that the synchronizer pair
    // can be placed together with no logic between them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1     <= sw_raw;
            s2     <= s1;
            db_q   <= db_nxt;
            cnt_q  <= cnt_nxt;
            rise_q <= (ev_nxt == EV_RISE);
            fall_q <= (ev_nxt == EV_FALL);
        end
    end

    // Next-state logic. Any cycle where the synchronized input agrees with
    // the accepted level discards all progress. The counter stops at TERM
    // and never wraps, because reaching TERM always either accepts the
    // level or clears the count.
    always_comb begin
        db_nxt  = db_q;
        cnt_nxt = cnt_q;
        ev_nxt  = EV_NONE;
        if (s2 == db_q) begin
            cnt_nxt = '0;
        end else if (cnt_q == TERM) begin
            db_nxt  = s2;
            cnt_nxt = '0;
            ev_nxt  = s2 ? EV_RISE : EV_FALL;
        end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // Outputs. All outputs except pulse_nxt come straight from flops.
    // pulse_nxt depends only on flops, so no path runs from sw_raw.
    assign db        = db_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign pulse_nxt = (ev_nxt != EV_NONE);

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH switch lines into a clean level plus per-bit rise/fall pulses and a changed flag.
// Latency: STABLE_CYCLES+2 clk edges from the first sampling edge; changed is aligned with the pulses.
// Backpressure: none. Outputs are levels and single-cycle pulses, and the consumer cannot stall them.
//
// Ports:
//   clk, reset : system clock, asynchronous active-low reset
//   bus        : switch_debouncer_if.slave (sw_raw in; sw_db, rise, fall, changed out)
module switch_debouncer
    import periph_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int CNT_W         = DEBOUNCE_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    switch_debouncer_if.slave     bus
);

    logic [WIDTH-1:0] sw_raw_w;
    logic [WIDTH-1:0] db_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] pulse_nxt_w;
    logic             changed_q;

    assign sw_raw_w = bus.sw_raw;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .sw_raw    (sw_raw_w[gi]),
            .db        (db_w[gi]),
            .rise      (rise_w[gi]),
            .fall      (fall_w[gi]),
            .pulse_nxt (pulse_nxt_w[gi])
        );
    end

    // The OR is taken over the next-state pulse terms. As a result,
    // changed_q is loaded on the same edge as the rise/fall flops and the
    // flag lines up exactly with the pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |pulse_nxt_w;
        end
    end

    assign bus.sw_db   = db_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer. One instance uses STABLE_CYCLES=4 and a second uses STABLE_CYCLES=1.
// Each expected pulse event (cycle, level, rise, fall) is queued when its stimulus is driven,
// and it is popped when the DUT reports a pulse.
module tb_switch_debouncer;
    import periph_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    ev_t  q_a[$];
    ev_t  q_b[$];

    switch_debouncer_if #(.WIDTH(8)) ifa ();
    switch_debouncer_if #(.WIDTH(8)) ifb ();

    switch_debouncer #(
        .WIDTH         (8),
        .STABLE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .CNT_W         (DEBOUNCE_CNT_W)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    switch_debouncer #(
        .WIDTH         (8),
        .STABLE_CYCLES (1),
        .CNT_W         (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer. Any pulse or changed flag must match the head of its queue.
    task automatic mon_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            if (ifa.changed || ((ifa.rise | ifa.fall) != 8'h00)) begin
                total++;
                if (q_a.size() == 0) begin
                    bad++;
                    $display("FAIL mon_a unexpected pulse cyc=%0d db=%h rise=%h fall=%h changed=%b",
                             cyc, ifa.sw_db, ifa.rise, ifa.fall, ifa.changed);
                end else begin
                    e = q_a.pop_front();
                    if (cyc !== e.cyc || ifa.sw_db !== e.db || ifa.rise !== e.rise ||
                        ifa.fall !== e.fall || ifa.changed !== 1'b1) begin
                        bad++;
                        $display("FAIL mon_a got cyc=%0d db=%h rise=%h fall=%h chg=%b exp cyc=%0d db=%h rise=%h fall=%h chg=1",
                                 cyc, ifa.sw_db, ifa.rise, ifa.fall, ifa.changed, e.cyc, e.db, e.rise, e.fall);
                    end
                end
            end
            if (ifb.changed || ((ifb.rise | ifb.fall) != 8'h00)) begin
                total++;
                if (q_b.size() == 0) begin
                    bad++;
                    $display("FAIL mon_b unexpected pulse cyc=%0d db=%h rise=%h fall=%h changed=%b",
                             cyc, ifb.sw_db, ifb.rise, ifb.fall, ifb.changed);
                end else begin
                    e = q_b.pop_front();
                    if (cyc !== e.cyc || ifb.sw_db !== e.db || ifb.rise !== e.rise ||
                        ifb.fall !== e.fall || ifb.changed !== 1'b1) begin
                        bad++;
                        $display("FAIL mon_b got cyc=%0d db=%h rise=%h fall=%h chg=%b exp cyc=%0d db=%h rise=%h fall=%h chg=1",
                                 cyc, ifb.sw_db, ifb.rise, ifb.fall, ifb.changed, e.cyc, e.db, e.rise, e.fall);
                    end
                end
            end
        end
    endtask

    // Waits, within a bounded number of cycles, for both queues to empty.
    // Afterwards it waits a few more cycles so that stray pulses reach the monitor.
    task automatic drain();
        for (int i = 0; i < 30 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifa.sw_raw = 8'hFF;
        ifb.sw_raw = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if (ifa.sw_db !== 8'h00) begin bad++; $display("FAIL reset_sw_db got=%h exp=00", ifa.sw_db); end
        total++;
        if (ifa.rise !== 8'h00) begin bad++; $display("FAIL reset_rise got=%h exp=00", ifa.rise); end
        total++;
        if (ifa.fall !== 8'h00) begin bad++; $display("FAIL reset_fall got=%h exp=00", ifa.fall); end
        total++;
        if (ifa.changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", ifa.changed); end
        total++;
        if (ifb.sw_db !== 8'h00) begin bad++; $display("FAIL reset_b_sw_db got=%h exp=00", ifb.sw_db); end
        reset = 1'b1;
        q_a.push_back('{cyc + 6, 8'hFF, 8'hFF, 8'h00});
        repeat (5) @(negedge clk);
        total++;
        if (ifa.sw_db !== 8'h00) begin bad++; $display("FAIL reset_early_db got=%h exp=00", ifa.sw_db); end
        drain();
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL reset_release_pulse missing got=%0d pending exp=0", q_a.size()); end
        total++;
        if (ifa.sw_db !== 8'hFF) begin bad++; $display("FAIL reset_release_db got=%h exp=ff", ifa.sw_db); end
        q_a.delete();
    endtask

    task automatic test_clean_change();
        @(negedge clk);
        ifa.sw_raw = 8'h00;
        q_a.push_back('{cyc + 6, 8'h00, 8'h00, 8'hFF});
        drain();
        total++;
        if (ifa.sw_db !== 8'h00) begin bad++; $display("FAIL clean_fall_db got=%h exp=00", ifa.sw_db); end
        @(negedge clk);
        ifa.sw_raw = 8'h08;
        q_a.push_back('{cyc + 6, 8'h08, 8'h08, 8'h00});
        drain();
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL clean_pending got=%0d exp=0", q_a.size()); end
        total++;
        if (ifa.sw_db !== 8'h08) begin bad++; $display("FAIL clean_db got=%h exp=08", ifa.sw_db); end
        q_a.delete();
    endtask

    task automatic test_bounce();
        logic pat [9];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ifa.sw_raw = {7'b0000100, pat[i]};
            if (i == 5) q_a.push_back('{cyc + 6, 8'h09, 8'h01, 8'h00});
        end
        #1;
        total++;
        if (ifa.sw_db !== 8'h08) begin bad++; $display("FAIL bounce_mid_db got=%h exp=08", ifa.sw_db); end
        drain();
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL bounce_pending got=%0d exp=0", q_a.size()); end
        total++;
        if (ifa.sw_db !== 8'h09) begin bad++; $display("FAIL bounce_db got=%h exp=09", ifa.sw_db); end
        q_a.delete();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        ifa.sw_raw = 8'h00;
        q_a.push_back('{cyc + 6, 8'h00, 8'h00, 8'h09});
        drain();
        @(negedge clk);
        ifa.sw_raw = 8'hA5;
        q_a.push_back('{cyc + 6, 8'hA5, 8'hA5, 8'h00});
        drain();
        total++;
        if (ifa.sw_db !== 8'hA5) begin bad++; $display("FAIL simul_a5_db got=%h exp=a5", ifa.sw_db); end
        @(negedge clk);
        ifa.sw_raw = 8'h5A;
        q_a.push_back('{cyc + 6, 8'h5A, 8'h5A, 8'hA5});
        drain();
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL simul_pending got=%0d exp=0", q_a.size()); end
        total++;
        if (ifa.sw_db !== 8'h5A) begin bad++; $display("FAIL simul_5a_db got=%h exp=5a", ifa.sw_db); end
        q_a.delete();
    endtask

    task automatic test_reset_mid_count();
        @(negedge clk);
        ifa.sw_raw = 8'hDA;
        repeat (4) @(negedge clk);
        total++;
        if (dut_a.g_bit[7].u_bit.cnt_q !== 19'd2) begin
            bad++; $display("FAIL midrst_cnt_before got=%0d exp=2", dut_a.g_bit[7].u_bit.cnt_q);
        end
        reset = 1'b0;
        #1;
        total++;
        if (dut_a.g_bit[7].u_bit.cnt_q !== 19'd0) begin
            bad++; $display("FAIL midrst_cnt_cleared got=%0d exp=0", dut_a.g_bit[7].u_bit.cnt_q);
        end
        total++;
        if (ifa.sw_db !== 8'h00) begin bad++; $display("FAIL midrst_db_cleared got=%h exp=00", ifa.sw_db); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q_a.push_back('{cyc + 6, 8'hDA, 8'hDA, 8'h00});
        drain();
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL midrst_pending got=%0d exp=0", q_a.size()); end
        total++;
        if (ifa.sw_db !== 8'hDA) begin bad++; $display("FAIL midrst_db got=%h exp=da", ifa.sw_db); end
        q_a.delete();
    endtask

    task automatic test_stable_one();
        @(negedge clk);
        ifb.sw_raw = 8'h02;
        q_b.push_back('{cyc + 3, 8'h02, 8'h02, 8'h00});
        q_b.push_back('{cyc + 4, 8'h00, 8'h00, 8'h02});
        @(negedge clk);
        ifb.sw_raw = 8'h00;
        drain();
        total++;
        if (q_b.size() != 0) begin bad++; $display("FAIL stable1_pending got=%0d exp=0", q_b.size()); end
        total++;
        if (ifb.sw_db !== 8'h00) begin bad++; $display("FAIL stable1_db got=%h exp=00", ifb.sw_db); end
        q_b.delete();
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        ifa.sw_raw = 8'h00;
        ifb.sw_raw = 8'h00;
        fork
            mon_loop();
        join_none
        fork
            begin
                #100000;
                $display("FAIL watchdog timeout cyc=%0d", cyc);
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_clean_change();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_stable_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
